ama_riscv_hpm: RTL and testbench
================================

# ama_riscv_hpm

Parametrised hardware performance-monitor counter bank, the generalisation of the fixed mcycle/minstret CSR pair. It provides NUM_CNT event counters (mhpmcounter3.., with high halves), per-counter event selectors (mhpmevent3..), and a per-counter inhibit register (mcountinhibit). It sits beside the CSR file in the writeback stage. It receives one-cycle event pulses from the pipeline, caches and branch predictor, and serves CSR accesses with a registered response.

## Interface
Parameters:
- NUM_CNT, 4, number of counters, 1..29, mapped from index 3 upward
- CNT_W, 64, counter width, 33..64
- NUM_EVT, 16, number of event inputs, 1..255
- Derived: EVT_SEL_W = $clog2(NUM_EVT+1)

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1, core clock
- rst, in, 1, asynchronous active-high reset
- evt_i, in, NUM_EVT, event pulses; bit k counts when high on a clk edge
- csr_en, in, 1, CSR access this cycle
- csr_we, in, 1, access writes
- csr_op, in, csr_op_t, RW/RS/RC; NONE means no write
- csr_addr, in, 12, CSR address
- csr_wdata, in, ARCH_WIDTH, write operand
- csr_hit, out, 1, registered; previous access matched a block address
- csr_rdata, out, ARCH_WIDTH, registered read data
- ovf_o, out, 1, OR of sticky overflow flags (macro only, see Configuration)

## Operation
- Address map, for i in 0..NUM_CNT-1:
  - counter low half at 0xB03+i
  - counter high half at 0xB83+i
  - event selector at 0x323+i
  - mcountinhibit at 0x320; bit 3+i inhibits counter i, all other bits read 0
- Event selector holds EVT_SEL_W bits and ignores upper bits on write.
  - Value 0: counter disabled.
  - Value k in 1..NUM_EVT: counts evt_i[k-1].
  - Values above NUM_EVT: treated as disabled, but read back as written.
- Increment: a counter adds +1 on a clk edge when its selected event is high and its inhibit bit is 0.
- Wrap: the counter wraps modulo 2^CNT_W. Bits at or above CNT_W read 0 and ignore writes.
- Write value: new = wdata (RW), old | wdata (RS), old & ~wdata (RC). The write applies when csr_en & csr_we & (csr_op != CSR_OP_NONE) & hit.
- Write and increment in the same cycle: the write wins and the increment for that cycle is lost. A write to one half leaves the other half unchanged.
- Reads return the value before any write or increment on the same edge.
- Unmapped address:
  - csr_hit = 0 and csr_rdata = 0 on the next cycle
  - no state change

## Timing
- Registered CSR access: csr_hit and csr_rdata update on the edge after the csr_en cycle, then hold until the next access.
- Counter latency: an event pulse in cycle N is visible to a read issued in cycle N+1.
- Back-to-back accesses are allowed every cycle.
- Reset values:
  - all counters 0
  - all selectors 0
  - mcountinhibit 0
  - csr_hit 0, csr_rdata 0, ovf_o 0
- Reset mid-operation clears everything immediately; no partial state survives.

## Configuration
- AMA_RISCV_HPM_OVF_EN defined:
  - Each counter carries a sticky overflow flag, set when an increment wraps the counter to 0.
  - The flags read at 0xDA0 with bit 3+i for counter i; this address is read-only and writes are ignored.
  - Any write to a counter's low or high half clears its flag.
  - ovf_o is registered and equals the OR of all flags.
- AMA_RISCV_HPM_OVF_EN undefined:
  - No flags exist and 0xDA0 is unmapped (hit = 0).
  - ovf_o is tied to 0.

## Structure
- Shared package gains:
  - csr_addr_t entries CSR_MHPMCOUNTER3, CSR_MHPMCOUNTER3H, CSR_MHPMEVENT3, CSR_MCOUNTINHIBIT, CSR_SCOUNTOVF
  - parameter HPM_NUM_CNT
- One sub-module, ama_riscv_hpm_cnt, instantiated NUM_CNT times via generate. It holds a single counter with its selector mux, inhibit gate, write merge and overflow flag.

## Test plan
- Reset defaults: after reset, read 0xB03, 0x323 and 0x320 -> csr_rdata = 0 and csr_hit = 1 for each; read 0xB00 -> csr_hit = 0, csr_rdata = 0.
- Counting: write 0x323 = 2, pulse evt_i[1] for 10 cycles, read 0xB03 -> 10; read 0xB83 -> 0.
- Inhibit plus RS/RC: RS 0x320 with 0x8 freezes counter 0 across 5 pulses (value unchanged); RC 0x320 with 0x8 resumes counting.
- Write-versus-increment collision: RW 0xB03 = 0x100 on the same cycle as an active event -> read returns 0x100.
- Wrap: CNT_W = 40, preload high half 0xFF and low half 0xFFFFFFFF, one event -> both halves read 0. With AMA_RISCV_HPM_OVF_EN defined, ovf_o = 1 on the following cycle and 0xDA0 reads 0x8; a write to 0xB03 then clears both.
- Mid-operation reset: assert rst during counting -> every counter and csr_rdata read 0 afterwards.

Source files
------------

// File: rtl/ama_riscv_hpm_pkg.sv
// Shared types for the hardware performance-monitor counter bank: CSR operation
// codes, the CSR addresses the bank decodes and the default counter count.
package ama_riscv_hpm_pkg;

    localparam int unsigned ARCH_WIDTH  = 32;
    localparam int unsigned HPM_NUM_CNT = 4;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_t;

    // Base addresses; counter i lives at base + i
    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MHPMEVENT3    = 12'h323,
        CSR_MHPMCOUNTER3  = 12'hB03,
        CSR_MHPMCOUNTER3H = 12'hB83,
        CSR_SCOUNTOVF     = 12'hDA0
    } csr_addr_t;

endpackage

// File: rtl/ama_riscv_hpm_if.sv
// CSR access bus between the writeback-stage CSR logic (master) and the
// performance-monitor bank (slave). Response signals are registered by the slave.
interface ama_riscv_hpm_if;
    import ama_riscv_hpm_pkg::*;

    logic                  csr_en;
    logic                  csr_we;
    csr_op_t               csr_op;
    logic [11:0]           csr_addr;
    logic [ARCH_WIDTH-1:0] csr_wdata;
    logic                  csr_hit;
    logic [ARCH_WIDTH-1:0] csr_rdata;

    modport master (
        output csr_en, csr_we, csr_op, csr_addr, csr_wdata,
        input  csr_hit, csr_rdata
    );

    modport slave (
        input  csr_en, csr_we, csr_op, csr_addr, csr_wdata,
        output csr_hit, csr_rdata
    );

endinterface

// File: rtl/ama_riscv_hpm_cnt.sv
// One performance counter: event selector mux, inhibit gate, CSR write merge for
// the low/high halves and, with AMA_RISCV_HPM_OVF_EN, a sticky wrap flag.
module ama_riscv_hpm_cnt
    import ama_riscv_hpm_pkg::*;
#(
    parameter int unsigned CNT_W     = 64,
    parameter int unsigned NUM_EVT   = 16,
    parameter int unsigned EVT_SEL_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVT-1:0]    evt,
    input  logic                  inhibit,
    input  logic                  lo_we,
    input  logic                  hi_we,
    input  logic                  sel_we,
    input  csr_op_t               csr_op,
    input  logic [ARCH_WIDTH-1:0] csr_wdata,
    output logic [CNT_W-1:0]      cnt,
    output logic [EVT_SEL_W-1:0]  sel
`ifdef AMA_RISCV_HPM_OVF_EN
    ,
    output logic                  ovf,
    output logic                  ovf_next
`endif
);
    localparam int unsigned HI_W = CNT_W - ARCH_WIDTH;

    logic [CNT_W-1:0]     cnt_q, cnt_d, wr_val, wr_mask, merged;
    logic [EVT_SEL_W-1:0] sel_q, sel_d, sel_wr;
    logic                 evt_hit, inc;

    // Selected event; code 0 and codes above NUM_EVT never match
    always_comb begin
        evt_hit = 1'b0;
        for (int k = 1; k <= NUM_EVT; k++) begin
            if (sel_q == EVT_SEL_W'(k)) evt_hit = evt[k-1];
        end
    end

    assign inc = evt_hit && !inhibit;

    // Counter next state: a CSR write to either half beats the increment
    always_comb begin
        wr_val  = '0;
        wr_mask = '0;
        if (hi_we) begin
            wr_val[CNT_W-1:ARCH_WIDTH]  = csr_wdata[HI_W-1:0];
            wr_mask[CNT_W-1:ARCH_WIDTH] = '1;
        end else begin
            wr_val[ARCH_WIDTH-1:0]  = csr_wdata;
            wr_mask[ARCH_WIDTH-1:0] = '1;
        end
        case (csr_op)
            CSR_OP_RW: merged = (cnt_q & ~wr_mask) | wr_val;
            CSR_OP_RS: merged = cnt_q | wr_val;
            CSR_OP_RC: merged = cnt_q & ~wr_val;
            default:   merged = cnt_q;
        endcase
        if (lo_we || hi_we) cnt_d = merged;
        else if (inc)       cnt_d = cnt_q + 1'b1;
        else                cnt_d = cnt_q;
    end

    // Selector next state; upper write-data bits are dropped
    always_comb begin
        sel_wr = csr_wdata[EVT_SEL_W-1:0];
        sel_d  = sel_q;
        if (sel_we) begin
            case (csr_op)
                CSR_OP_RW: sel_d = sel_wr;
                CSR_OP_RS: sel_d = sel_q | sel_wr;
                CSR_OP_RC: sel_d = sel_q & ~sel_wr;
                default:   sel_d = sel_q;
            endcase
        end
    end

    // Counter and selector state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    assign cnt = cnt_q;
    assign sel = sel_q;

`ifdef AMA_RISCV_HPM_OVF_EN
    logic ovf_q;

    // Sticky wrap flag: set when an increment rolls over, cleared by any counter write
    always_comb begin
        ovf_next = ovf_q;
        if (lo_we || hi_we)       ovf_next = 1'b0;
        else if (inc && &cnt_q)   ovf_next = 1'b1;
    end

    // Wrap flag state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_next;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: rtl/ama_riscv_hpm.sv
// Hardware performance-monitor counter bank: NUM_CNT event counters with
// selectors and an inhibit register, served over a registered CSR port.
// Optional feature macro: AMA_RISCV_HPM_OVF_EN (sticky overflow flags at 0xDA0, ovf_o).
module ama_riscv_hpm
    import ama_riscv_hpm_pkg::*;
#(
    parameter int unsigned NUM_CNT = HPM_NUM_CNT,
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned NUM_EVT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] evt_i,
    ama_riscv_hpm_if.slave     csr,
    output logic               ovf_o
);
    localparam int unsigned EVT_SEL_W = $clog2(NUM_EVT + 1);

    logic                  wr_en, inh_we, hit, hit_q;
    logic [ARCH_WIDTH-1:0] rdata, rdata_q;
    logic [NUM_CNT-1:0]    inh_q, inh_d, lo_we, hi_we, sel_we;
    logic [CNT_W-1:0]      cnt [NUM_CNT];
    logic [EVT_SEL_W-1:0]  sel [NUM_CNT];
`ifdef AMA_RISCV_HPM_OVF_EN
    logic [NUM_CNT-1:0]    ovf, ovf_next;
    logic                  ovf_q;
`endif

    assign wr_en = csr.csr_en && csr.csr_we && (csr.csr_op != CSR_OP_NONE);

    // Address decode: per-register write strobes and the pre-edge read value
    always_comb begin
        hit    = 1'b0;
        rdata  = '0;
        inh_we = 1'b0;
        lo_we  = '0;
        hi_we  = '0;
        sel_we = '0;
        if (csr.csr_addr == CSR_MCOUNTINHIBIT) begin
            hit                = 1'b1;
            rdata[3+:NUM_CNT]  = inh_q;
            inh_we             = wr_en;
        end
`ifdef AMA_RISCV_HPM_OVF_EN
        if (csr.csr_addr == CSR_SCOUNTOVF) begin
            hit               = 1'b1;
            rdata[3+:NUM_CNT] = ovf;
        end
`endif
        for (int i = 0; i < NUM_CNT; i++) begin
            if (csr.csr_addr == 12'(CSR_MHPMCOUNTER3 + i)) begin
                hit      = 1'b1;
                rdata    = cnt[i][ARCH_WIDTH-1:0];
                lo_we[i] = wr_en;
            end
            if (csr.csr_addr == 12'(CSR_MHPMCOUNTER3H + i)) begin
                hit                              = 1'b1;
                rdata[CNT_W-ARCH_WIDTH-1:0]      = cnt[i][CNT_W-1:ARCH_WIDTH];
                hi_we[i]                         = wr_en;
            end
            if (csr.csr_addr == 12'(CSR_MHPMEVENT3 + i)) begin
                hit                    = 1'b1;
                rdata[EVT_SEL_W-1:0]   = sel[i];
                sel_we[i]              = wr_en;
            end
        end
    end

    // Inhibit register write merge; only bits 3.. are implemented
    always_comb begin
        inh_d = inh_q;
        if (inh_we) begin
            case (csr.csr_op)
                CSR_OP_RW: inh_d = csr.csr_wdata[3+:NUM_CNT];
                CSR_OP_RS: inh_d = inh_q | csr.csr_wdata[3+:NUM_CNT];
                CSR_OP_RC: inh_d = inh_q & ~csr.csr_wdata[3+:NUM_CNT];
                default:   inh_d = inh_q;
            endcase
        end
    end

    // Inhibit state and registered CSR response, held between accesses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_q   <= '0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            inh_q <= inh_d;
            if (csr.csr_en) begin
                hit_q   <= hit;
                rdata_q <= rdata;
            end
        end
    end

    assign csr.csr_hit   = hit_q;
    assign csr.csr_rdata = rdata_q;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        ama_riscv_hpm_cnt #(
            .CNT_W     (CNT_W),
            .NUM_EVT   (NUM_EVT),
            .EVT_SEL_W (EVT_SEL_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .evt       (evt_i),
            .inhibit   (inh_q[i]),
            .lo_we     (lo_we[i]),
            .hi_we     (hi_we[i]),
            .sel_we    (sel_we[i]),
            .csr_op    (csr.csr_op),
            .csr_wdata (csr.csr_wdata),
            .cnt       (cnt[i]),
            .sel       (sel[i])
`ifdef AMA_RISCV_HPM_OVF_EN
            ,
            .ovf       (ovf[i]),
            .ovf_next  (ovf_next[i])
`endif
        );
    end

`ifdef AMA_RISCV_HPM_OVF_EN
    // Registered OR of the flags' next state so ovf_o tracks the flags edge for edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= |ovf_next;
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_ama_riscv_hpm.sv
// Self-checking bench for ama_riscv_hpm: directed scenarios plus randomized CSR
// traffic and event pulses, all compared against a behavioural register model.
`timescale 1ns/1ps
module tb_ama_riscv_hpm;
    import ama_riscv_hpm_pkg::*;

    localparam int unsigned NUM_CNT  = 4;
    localparam int unsigned CNT_W    = 40;
    localparam int unsigned NUM_EVT  = 16;
    localparam int unsigned SEL_W    = $clog2(NUM_EVT + 1);
    localparam logic [63:0] CNT_MASK = (64'd1 << CNT_W) - 64'd1;
    localparam logic [31:0] SEL_MASK = (32'd1 << SEL_W) - 32'd1;
    localparam logic [31:0] INH_MASK = ((32'd1 << NUM_CNT) - 32'd1) << 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_EVT-1:0] evt;
    logic               ovf_o;

    ama_riscv_hpm_if bus ();

    ama_riscv_hpm #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .NUM_EVT (NUM_EVT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .evt_i (evt),
        .csr   (bus),
        .ovf_o (ovf_o)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents
    logic [63:0]        m_cnt [NUM_CNT];
    logic [31:0]        m_sel [NUM_CNT];
    logic [31:0]        m_inh;
    logic [NUM_CNT-1:0] m_ovf;
    logic               exp_hit;
    logic [31:0]        exp_rdata;
    logic               exp_ovf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input csr_op_t op, input logic [31:0] old,
                                          input logic [31:0] wd);
        case (op)
            CSR_OP_RW: return wd;
            CSR_OP_RS: return old | wd;
            CSR_OP_RC: return old & ~wd;
            default:   return old;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CNT; i++) begin
            m_cnt[i] = '0;
            m_sel[i] = '0;
        end
        m_inh     = '0;
        m_ovf     = '0;
        exp_hit   = 1'b0;
        exp_rdata = '0;
        exp_ovf   = 1'b0;
    endtask

    // One clock edge of architectural behaviour: read old state, then write/increment
    task automatic model_step(input logic en, input logic we, input csr_op_t op,
                              input logic [11:0] addr, input logic [31:0] wd,
                              input logic [NUM_EVT-1:0] ev);
        logic               h;
        logic [31:0]        rd;
        logic               wr;
        logic               wrote;
        logic [NUM_CNT-1:0] inc;
        wr = en && we && (op != CSR_OP_NONE);
        h  = 1'b0;
        rd = '0;
        if (addr == 12'h320) begin h = 1'b1; rd = m_inh; end
`ifdef AMA_RISCV_HPM_OVF_EN
        if (addr == 12'hDA0) begin h = 1'b1; rd = 32'(m_ovf) << 3; end
`endif
        for (int i = 0; i < NUM_CNT; i++) begin
            if (addr == 12'hB03 + i) begin h = 1'b1; rd = m_cnt[i][31:0]; end
            if (addr == 12'hB83 + i) begin h = 1'b1; rd = m_cnt[i][63:32]; end
            if (addr == 12'h323 + i) begin h = 1'b1; rd = m_sel[i]; end
            inc[i] = (m_sel[i] >= 1) && (m_sel[i] <= NUM_EVT) && ev[m_sel[i] - 1]
                     && !m_inh[3 + i];
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            wrote = 1'b0;
            if (wr && addr == 12'hB03 + i) begin
                m_cnt[i] = {m_cnt[i][63:32], merge(op, m_cnt[i][31:0], wd)} & CNT_MASK;
                wrote    = 1'b1;
            end
            if (wr && addr == 12'hB83 + i) begin
                m_cnt[i] = {merge(op, m_cnt[i][63:32], wd), m_cnt[i][31:0]} & CNT_MASK;
                wrote    = 1'b1;
            end
            if (wr && addr == 12'h323 + i) m_sel[i] = merge(op, m_sel[i], wd) & SEL_MASK;
            if (wrote) begin
                m_ovf[i] = 1'b0;
            end else if (inc[i]) begin
                if (m_cnt[i] == CNT_MASK) m_ovf[i] = 1'b1;
                m_cnt[i] = (m_cnt[i] + 64'd1) & CNT_MASK;
            end
        end
        if (wr && addr == 12'h320) m_inh = merge(op, m_inh, wd) & INH_MASK;
        if (en) begin
            exp_hit   = h;
            exp_rdata = rd;
        end
`ifdef AMA_RISCV_HPM_OVF_EN
        exp_ovf = |m_ovf;
`else
        exp_ovf = 1'b0;
`endif
    endtask

    // Drive one cycle, advance the model, check the registered outputs after the edge
    task automatic step(input logic en, input logic we, input csr_op_t op,
                        input logic [11:0] addr, input logic [31:0] wd,
                        input logic [NUM_EVT-1:0] ev);
        bus.csr_en    = en;
        bus.csr_we    = we;
        bus.csr_op    = op;
        bus.csr_addr  = addr;
        bus.csr_wdata = wd;
        evt           = ev;
        model_step(en, we, op, addr, wd, ev);
        @(posedge clk);
        #1;
        check_eq($sformatf("hit@%03h", addr), bus.csr_hit, exp_hit);
        check_eq($sformatf("rdata@%03h", addr), bus.csr_rdata, exp_rdata);
        check_eq("ovf_o", ovf_o, exp_ovf);
    endtask

    task automatic rd(input logic [11:0] addr);
        step(1'b1, 1'b0, CSR_OP_NONE, addr, '0, '0);
    endtask

    task automatic wr(input csr_op_t op, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [NUM_EVT-1:0] ev);
        step(1'b1, 1'b1, op, addr, wd, ev);
    endtask

    task automatic idle(input logic [NUM_EVT-1:0] ev);
        step(1'b0, 1'b0, CSR_OP_NONE, '0, '0, ev);
    endtask

    task automatic run_random(input int cycles);
        int unsigned   pick;
        int unsigned   idx;
        logic [11:0]   a;
        logic [31:0]   wd;
        for (int n = 0; n < cycles; n++) begin
            pick = $urandom_range(0, 15);
            idx  = $urandom_range(0, NUM_CNT - 1);
            case (pick)
                0, 1, 2, 3: a = 12'(12'hB03 + idx);
                4, 5:       a = 12'(12'hB83 + idx);
                6, 7:       a = 12'(12'h323 + idx);
                8:          a = 12'h320;
                9:          a = 12'hDA0;
                10:         a = 12'(12'hB00 + $urandom_range(0, 2));
                11:         a = 12'(12'hB03 + NUM_CNT);
                12:         a = 12'(12'h323 + NUM_CNT);
                default:    a = 12'(12'hB03 + idx);
            endcase
            wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 csr_op_t'($urandom_range(0, 3)), a, wd, NUM_EVT'($urandom & $urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        evt           = '0;
        bus.csr_en    = 1'b0;
        bus.csr_we    = 1'b0;
        bus.csr_op    = CSR_OP_NONE;
        bus.csr_addr  = '0;
        bus.csr_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_hit", bus.csr_hit, 1'b0);
        check_eq("reset_rdata", bus.csr_rdata, 32'd0);
        check_eq("reset_ovf", ovf_o, 1'b0);

        // Reset defaults
        rd(12'hB03); check_eq("dflt_b03_hit", bus.csr_hit, 1'b1);
        check_eq("dflt_b03", bus.csr_rdata, 32'd0);
        rd(12'h323); check_eq("dflt_323_hit", bus.csr_hit, 1'b1);
        rd(12'h320); check_eq("dflt_320_hit", bus.csr_hit, 1'b1);
        check_eq("dflt_320", bus.csr_rdata, 32'd0);
        rd(12'hB00); check_eq("unmapped_hit", bus.csr_hit, 1'b0);
        check_eq("unmapped_rdata", bus.csr_rdata, 32'd0);

        // Counting on evt_i[1]
        wr(CSR_OP_RW, 12'h323, 32'd2, '0);
        repeat (10) idle(16'h0002);
        rd(12'hB03); check_eq("count10", bus.csr_rdata, 32'd10);
        rd(12'hB83); check_eq("count10_hi", bus.csr_rdata, 32'd0);

        // Inhibit via RS, resume via RC
        wr(CSR_OP_RS, 12'h320, 32'h8, '0);
        repeat (5) idle(16'h0002);
        rd(12'hB03); check_eq("inhibited", bus.csr_rdata, 32'd10);
        wr(CSR_OP_RC, 12'h320, 32'h8, '0);
        repeat (3) idle(16'h0002);
        rd(12'hB03); check_eq("resumed", bus.csr_rdata, 32'd13);

        // Write beats a same-cycle increment
        wr(CSR_OP_RW, 12'hB03, 32'h100, 16'h0002);
        rd(12'hB03); check_eq("collision", bus.csr_rdata, 32'h100);

        // Wrap at 2^40
        wr(CSR_OP_RW, 12'hB83, 32'hFF, '0);
        wr(CSR_OP_RW, 12'hB03, 32'hFFFF_FFFF, '0);
        idle(16'h0002);
`ifdef AMA_RISCV_HPM_OVF_EN
        check_eq("wrap_ovf_o", ovf_o, 1'b1);
`endif
        rd(12'hB03); check_eq("wrap_lo", bus.csr_rdata, 32'd0);
        rd(12'hB83); check_eq("wrap_hi", bus.csr_rdata, 32'd0);
        rd(12'hDA0);
`ifdef AMA_RISCV_HPM_OVF_EN
        check_eq("scountovf", bus.csr_rdata, 32'h8);
        wr(CSR_OP_RW, 12'hB03, 32'd0, '0);
        check_eq("ovf_cleared", ovf_o, 1'b0);
        rd(12'hDA0); check_eq("scountovf_clr", bus.csr_rdata, 32'h0);
`else
        check_eq("da0_unmapped", bus.csr_hit, 1'b0);
        check_eq("ovf_tied", ovf_o, 1'b0);
`endif

        run_random(400);

        // Reset in the middle of counting
        wr(CSR_OP_RW, 12'h324, 32'd5, '0);
        repeat (4) idle('1);
        rd(12'hB04);
        bus.csr_en = 1'b1;
        evt        = '1;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("midrst_rdata", bus.csr_rdata, 32'd0);
        check_eq("midrst_hit", bus.csr_hit, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            rd(12'(12'hB03 + i)); check_eq("midrst_cnt", bus.csr_rdata, 32'd0);
            rd(12'(12'h323 + i)); check_eq("midrst_sel", bus.csr_rdata, 32'd0);
        end
        rd(12'h320); check_eq("midrst_inh", bus.csr_rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
